// File: rtl/result_acc_pkg.sv
// Shared types and helpers for the windowed result accumulator.
// Holds the FSM state encoding, the ceil-log2 helper and the default sample width.
package result_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } acc_state_t;

    localparam int DEF_DATA_W = 8;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/minmax_tracker.sv
// Running minimum/maximum over the samples of the current window.
// The o_*_next outputs give the comparison including the sample currently on i_data.
module minmax_tracker
    import result_acc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_update,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_min_next,
    output logic [DATA_W-1:0] o_max_next
);

    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;

    assign o_min_next = (i_data < r_min) ? i_data : r_min;
    assign o_max_next = (i_data > r_max) ? i_data : r_max;

    // Idle values (all-ones / zero) let the first update of a window load the sample.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_min <= '1;
            r_max <= '0;
        end else if (i_clear) begin
            r_min <= '1;
            r_max <= '0;
        end else if (i_load) begin
            r_min <= i_data;
            r_max <= i_data;
        end else if (i_update) begin
            r_min <= o_min_next;
            r_max <= o_max_next;
        end
    end

endmodule

// File: rtl/result_accumulator.sv
// Windowed sum/min/max of an unsigned sample stream with valid/ready on both sides.
// A result is held in FULL until consumed; a sample arriving on the consume cycle opens the next window.
module result_accumulator
    import result_acc_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int WINDOW = 4,
    localparam int SUM_W  = DATA_W + clog2(WINDOW),
    localparam int FC_W   = clog2(WINDOW) + 1
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FC_W-1:0]   fill_count
);

    localparam logic [FC_W-1:0] LAST_IDX = FC_W'(WINDOW - 1);

    acc_state_t        r_state;
    acc_state_t        w_next_state;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_final;
    logic              w_reload;
    logic              w_update;

    logic [SUM_W-1:0]  r_acc;
    logic [FC_W-1:0]   r_fill;
    logic [SUM_W-1:0]  r_out_sum;
    logic [DATA_W-1:0] r_out_min;
    logic [DATA_W-1:0] r_out_max;

    logic [SUM_W-1:0]  w_data_ext;
    logic [SUM_W-1:0]  w_sum_next;
    logic [DATA_W-1:0] w_min_next;
    logic [DATA_W-1:0] w_max_next;

    assign w_data_ext = {{(SUM_W - DATA_W){1'b0}}, in_data};
    assign w_sum_next = r_acc + w_data_ext;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_out_valid  = (r_state == FULL);
        w_in_ready   = reset_l && (!w_out_valid || out_ready);
        w_accept     = in_valid && w_in_ready;
        w_final      = 1'b0;
        w_reload     = 1'b0;
        w_update     = 1'b0;
        case (r_state)
            ACCUM: begin
                if (w_accept && (r_fill == LAST_IDX)) begin
                    w_final      = 1'b1;
                    w_next_state = FULL;
                end else if (w_accept) begin
                    w_update = 1'b1;
                end
            end
            FULL: begin
                if (out_ready) begin
                    w_next_state = ACCUM;
                    w_reload     = w_accept;
                end
            end
            default: w_next_state = ACCUM;
        endcase
    end

    minmax_tracker #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk        (clk),
        .reset_l    (reset_l),
        .i_clear    (w_final),
        .i_load     (w_reload),
        .i_update   (w_update),
        .i_data     (in_data),
        .o_min_next (w_min_next),
        .o_max_next (w_max_next)
    );

    // Payload registers move only on a final accept; they keep the last result between windows.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_acc     <= '0;
            r_fill    <= '0;
            r_out_sum <= '0;
            r_out_min <= '0;
            r_out_max <= '0;
        end else if (w_final) begin
            r_out_sum <= w_sum_next;
            r_out_min <= w_min_next;
            r_out_max <= w_max_next;
            r_acc     <= '0;
            r_fill    <= '0;
        end else if (w_reload) begin
            r_acc  <= w_data_ext;
            r_fill <= FC_W'(1);
        end else if (w_update) begin
            r_acc  <= w_sum_next;
            r_fill <= r_fill + FC_W'(1);
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_sum    = r_out_sum;
    assign out_min    = r_out_min;
    assign out_max    = r_out_max;
    assign fill_count = r_fill;

endmodule

// File: tb/tb_result_accumulator.sv
// Scoreboard bench: a window-level reference model queues expected results,
// and a negedge monitor compares handshake, fill level and payload every cycle.
module tb_result_accumulator;

    localparam int DATA_W = 8;
    localparam int WINDOW = 4;
    localparam int SUM_W  = 10;
    localparam int FC_W   = 3;

    typedef struct {
        int sum;
        int mn;
        int mx;
    } res_t;

    logic              clk = 1'b0;
    logic              reset_l = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_min;
    logic [DATA_W-1:0] out_max;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [FC_W-1:0]   fill_count;

    int vectors = 0;
    int miscompares = 0;

    int   win[$];
    res_t exp_q[$];
    res_t m_last = '{0, 0, 0};
    bit   m_valid = 1'b0;
    bit   m_acc = 1'b0;

    result_accumulator #(
        .DATA_W (DATA_W),
        .WINDOW (WINDOW)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sum    (out_sum),
        .out_min    (out_min),
        .out_max    (out_max),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_count (fill_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-window behaviour from the rules, evaluated at each active edge.
    always @(posedge clk) begin
        if (!reset_l) begin
            win.delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_acc   = 1'b0;
            m_last  = '{0, 0, 0};
        end else begin
            m_acc = in_valid && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_acc) begin
                win.push_back(int'(in_data));
                if (win.size() == WINDOW) begin
                    res_t r;
                    r = '{0, 255, 0};
                    foreach (win[i]) begin
                        r.sum += win[i];
                        if (win[i] < r.mn) r.mn = win[i];
                        if (win[i] > r.mx) r.mx = win[i];
                    end
                    exp_q.push_back(r);
                    m_last  = r;
                    m_valid = 1'b1;
                    win.delete();
                end
            end
        end
    end

    // Monitor: compares mid-cycle, pops the expected result on each output handshake.
    always @(negedge clk) begin
        res_t e;
        chk("in_ready", int'(in_ready), int'(reset_l && (!m_valid || out_ready)));
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("fill_count", int'(fill_count), win.size());
        e = (m_valid && exp_q.size() > 0) ? exp_q[0] : m_last;
        chk("out_sum", int'(out_sum), e.sum);
        chk("out_min", int'(out_min), e.mn);
        chk("out_max", int'(out_max), e.mx);
        if (m_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    task automatic step(input logic v, input int d, input logic r);
        in_valid  = v;
        in_data   = DATA_W'(d);
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1);
    endtask

    initial begin
        int seq[4];
        reset_l = 1'b0;
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        reset_l = 1'b1;
        idle(2);

        // Basic window and extremes
        seq = '{10, 20, 30, 40};
        foreach (seq[i]) step(1'b1, seq[i], 1'b1);
        idle(2);
        for (int i = 0; i < 4; i++) step(1'b1, 255, 1'b1);
        idle(2);
        seq = '{0, 255, 0, 255};
        foreach (seq[i]) step(1'b1, seq[i], 1'b1);
        idle(2);

        // Backpressure: result held, then consume with a sample on the same cycle
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b0);
        step(1'b1, 7, 1'b1);
        for (int i = 8; i <= 10; i++) step(1'b1, i, 1'b1);
        idle(2);

        // Bubbles between samples
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, i, 1'b1);
            idle(3);
        end
        idle(1);

        // Reset mid-window discards the partial window
        step(1'b1, 50, 1'b1);
        step(1'b1, 60, 1'b1);
        reset_l = 1'b0;
        step(1'b0, 0, 1'b1);
        reset_l = 1'b1;
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b1);
        idle(2);

        // Streaming without bubbles
        for (int k = 1; k <= 12; k++) step(1'b1, k, 1'b1);
        idle(3);

        // Randomized traffic with backpressure and occasional resets
        for (int n = 0; n < 800; n++) begin
            logic v;
            int   d;
            logic r;
            if (in_valid && !m_acc && reset_l) begin
                v = 1'b1;
                d = int'(in_data);
            end else begin
                v = ($urandom_range(0, 9) < 7);
                d = (($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 255 : 0)
                                                  : int'($urandom_range(0, 255)));
            end
            r = ($urandom_range(0, 9) < 6);
            reset_l = ($urandom_range(0, 199) != 0);
            step(v, d, r);
        end
        reset_l = 1'b1;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
